// File: rtl/axil_reg_wr_bridge_pkg.sv
// ---------------------------------------------------------------------------
// axil_reg_wr_bridge_pkg
// Shared constants and types for the AXI-lite register write bridge:
//   BRESP_OKAY / BRESP_SLVERR : AXI-lite write response codes
//   state_e                   : bridge FSM states
//   cnt_width()               : timeout counter width (at least 1 bit)
// ---------------------------------------------------------------------------
package axil_reg_wr_bridge_pkg;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REG  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // A zero timeout still needs a 1-bit counter so the register exists.
   function automatic int cnt_width(input int timeout);
      int w;
      w = (timeout > 0) ? $clog2(timeout + 1) : 1;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/axil_reg_wr_bridge_if.sv
// ---------------------------------------------------------------------------
// axil_reg_wr_bridge_if
// AXI-lite write channel bundle (AW, W, B).
//   master : drives awaddr/awprot/awvalid, wdata/wstrb/wvalid, bready
//   slave  : drives awready, wready, bresp/bvalid
// ---------------------------------------------------------------------------
interface axil_reg_wr_bridge_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );

endinterface

// File: rtl/axil_reg_wr_bridge.sv
// ---------------------------------------------------------------------------
// axil_reg_wr_bridge
// Terminates the AXI-lite write path and turns each write into a single
// enable/ack transaction on a simple register-file write port. One write is
// in flight at a time; the register may stretch it with reg_wr_wait, and a
// non-zero TIMEOUT aborts an unacknowledged write with SLVERR.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   s_axil          : AXI-lite write slave (AW, W, B)
//   reg_wr_addr/data/strb/en : register write request (held until done)
//   reg_wr_wait     : freeze the timeout counter
//   reg_wr_ack      : register has completed the write
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module axil_reg_wr_bridge
   import axil_reg_wr_bridge_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   axil_reg_wr_bridge_if.slave   s_axil,
   output logic [ADDR_WIDTH-1:0] reg_wr_addr,
   output logic [DATA_WIDTH-1:0] reg_wr_data,
   output logic [STRB_WIDTH-1:0] reg_wr_strb,
   output logic                  reg_wr_en,
   input  logic                  reg_wr_wait,
   input  logic                  reg_wr_ack
);

   localparam int                    ADDR_LSB  = $clog2(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ADDR_LSB;
   localparam int                    CNT_W     = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0]      CNT_INIT  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   if ((STRB_WIDTH != DATA_WIDTH / 8) || (DATA_WIDTH % 8 != 0)) begin : g_bad_strb
      $error("axil_reg_wr_bridge: STRB_WIDTH must equal DATA_WIDTH/8");
   end

   state_e                state_q;
   logic                  aw_cap_q, w_cap_q;
   logic                  awready_q, wready_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [STRB_WIDTH-1:0] strb_q;
   logic                  en_q;
   logic [CNT_W-1:0]      cnt_q;

   logic aw_hs, w_hs;
   logic aw_cap_d, w_cap_d;

   // ready is only ever high in IDLE, so these are IDLE-only handshakes
   assign aw_hs    = s_axil.awvalid & awready_q;
   assign w_hs     = s_axil.wvalid & wready_q;
   assign aw_cap_d = aw_cap_q | aw_hs;
   assign w_cap_d  = w_cap_q | w_hs;

   // protection bits carry no meaning for a register file
   logic unused_awprot;
   assign unused_awprot = ^s_axil.awprot;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         aw_cap_q  <= 1'b0;
         w_cap_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= BRESP_OKAY;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         en_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (aw_hs) addr_q <= s_axil.awaddr & ADDR_MASK;
               if (w_hs) begin
                  data_q <= s_axil.wdata;
                  strb_q <= s_axil.wstrb;
               end
               aw_cap_q  <= aw_cap_d;
               w_cap_q   <= w_cap_d;
               awready_q <= !aw_cap_d;
               wready_q  <= !w_cap_d;
               if (aw_cap_d && w_cap_d) begin
                  state_q <= ST_REG;
                  en_q    <= 1'b1;
                  cnt_q   <= CNT_INIT;
               end
            end
            ST_REG: begin
               // ack beats both wait and expiry
               if (reg_wr_ack) begin
                  en_q     <= 1'b0;
                  bvalid_q <= 1'b1;
                  bresp_q  <= BRESP_OKAY;
                  state_q  <= ST_RESP;
               end else if (reg_wr_wait) begin
                  cnt_q <= cnt_q;
               end else if ((TIMEOUT != 0) && (cnt_q == '0)) begin
                  en_q     <= 1'b0;
                  bvalid_q <= 1'b1;
                  bresp_q  <= BRESP_SLVERR;
                  state_q  <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_RESP: begin
               if (s_axil.bready) begin
                  bvalid_q  <= 1'b0;
                  aw_cap_q  <= 1'b0;
                  w_cap_q   <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_axil.awready = awready_q;
   assign s_axil.wready  = wready_q;
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;
   assign reg_wr_addr    = addr_q;
   assign reg_wr_data    = data_q;
   assign reg_wr_strb    = strb_q;
   assign reg_wr_en      = en_q;

endmodule

// File: tb/tb_axil_reg_wr_bridge.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_wr_bridge
// Self-checking bench for axil_reg_wr_bridge (TIMEOUT=4). Expected register
// writes and responses are queued when a write is launched and popped when
// the bridge presents them. Inputs change and outputs are sampled 1 time
// unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_axil_reg_wr_bridge;
   import axil_reg_wr_bridge_pkg::*;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] reg_wr_addr;
   logic [DW-1:0] reg_wr_data;
   logic [SW-1:0] reg_wr_strb;
   logic          reg_wr_en;
   logic          reg_wr_wait = 1'b0;
   logic          reg_wr_ack  = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
   } wr_t;

   wr_t        exp_wr[$];
   logic [1:0] exp_resp[$];

   axil_reg_wr_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   axil_reg_wr_bridge #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .s_axil(bus),
      .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
      .reg_wr_strb(reg_wr_strb), .reg_wr_en(reg_wr_en),
      .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive AW and W together; expected values are queued here
   task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] s, input logic [1:0] r);
      wr_t w;
      bus.awaddr = a; bus.awvalid = 1'b1;
      bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
      w.addr = a & 32'hFFFF_FFFC; w.data = d; w.strb = s;
      exp_wr.push_back(w);
      exp_resp.push_back(r);
   endtask

   task automatic clear_valids();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b exp 0", bus.awready); end
      checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %b exp 0", bus.wready); end
      checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b exp 0", bus.bvalid); end
      checks++; if (bus.bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp got %b exp 00", bus.bresp); end
      checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", reg_wr_en); end
      checks++; if ({reg_wr_addr, reg_wr_data, reg_wr_strb} !== '0) begin errors++; $display("FAIL rst_regport got %h/%h/%h exp 0", reg_wr_addr, reg_wr_data, reg_wr_strb); end
      rst = 1'b0;
      tick();
      checks++; if (bus.awready !== 1'b1) begin errors++; $display("FAIL rel_awready got %b exp 1", bus.awready); end
      checks++; if (bus.wready !== 1'b1) begin errors++; $display("FAIL rel_wready got %b exp 1", bus.wready); end
   endtask

   task automatic test_single();
      wr_t        w;
      logic [1:0] r;
      start_write(32'h1007, 32'hDEAD_BEEF, 4'hF, BRESP_OKAY);
      tick();
      clear_valids();
      w = exp_wr.pop_front();
      checks++; if (reg_wr_en !== 1'b1) begin errors++; $display("FAIL single_en got %b exp 1", reg_wr_en); end
      checks++; if (reg_wr_addr !== w.addr) begin errors++; $display("FAIL single_addr got %h exp %h", reg_wr_addr, w.addr); end
      checks++; if (reg_wr_data !== w.data) begin errors++; $display("FAIL single_data got %h exp %h", reg_wr_data, w.data); end
      checks++; if (reg_wr_strb !== w.strb) begin errors++; $display("FAIL single_strb got %h exp %h", reg_wr_strb, w.strb); end
      checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL single_awready got %b exp 0", bus.awready); end
      reg_wr_ack = 1'b1;
      tick();
      reg_wr_ack = 1'b0;
      r = exp_resp.pop_front();
      checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL single_en_drop got %b exp 0", reg_wr_en); end
      checks++; if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL single_bvalid got %b exp 1", bus.bvalid); end
      checks++; if (bus.bresp !== r) begin errors++; $display("FAIL single_bresp got %b exp %b", bus.bresp, r); end
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL single_bdone got %b exp 0", bus.bvalid); end
      checks++; if ({bus.awready, bus.wready} !== 2'b11) begin errors++; $display("FAIL single_ready_back got %b exp 11", {bus.awready, bus.wready}); end
   endtask

   task automatic test_w_before_aw();
      wr_t        w;
      logic [1:0] r;
      bus.wdata = 32'h1234_5678; bus.wstrb = 4'h3; bus.wvalid = 1'b1;
      w.addr = 32'h20; w.data = 32'h1234_5678; w.strb = 4'h3;
      exp_wr.push_back(w); exp_resp.push_back(BRESP_OKAY);
      tick();
      // a second W stays valid; it must wait for the B handshake
      bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hC;
      checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL wfirst_wready got %b exp 0", bus.wready); end
      checks++; if (bus.awready !== 1'b1) begin errors++; $display("FAIL wfirst_awready got %b exp 1", bus.awready); end
      tick(); tick();
      checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL wfirst_early_en got %b exp 0", reg_wr_en); end
      bus.awaddr = 32'h20; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      w = exp_wr.pop_front();
      checks++; if (reg_wr_en !== 1'b1) begin errors++; $display("FAIL wfirst_en got %b exp 1", reg_wr_en); end
      checks++; if ({reg_wr_addr, reg_wr_data, reg_wr_strb} !== {w.addr, w.data, w.strb}) begin errors++; $display("FAIL wfirst_port got %h/%h/%h exp %h/%h/%h", reg_wr_addr, reg_wr_data, reg_wr_strb, w.addr, w.data, w.strb); end
      reg_wr_ack = 1'b1;
      tick();
      reg_wr_ack = 1'b0;
      r = exp_resp.pop_front();
      checks++; if ({bus.bvalid, bus.bresp} !== {1'b1, r}) begin errors++; $display("FAIL wfirst_b got %b/%b exp 1/%b", bus.bvalid, bus.bresp, r); end
      checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL wfirst_w2_held got %b exp 0", bus.wready); end
      w.addr = 32'h44; w.data = 32'hCAFE_F00D; w.strb = 4'hC;
      exp_wr.push_back(w); exp_resp.push_back(BRESP_OKAY);
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      checks++; if (bus.wready !== 1'b1) begin errors++; $display("FAIL w2_wready got %b exp 1", bus.wready); end
      bus.awaddr = 32'h44; bus.awvalid = 1'b1;
      tick();
      clear_valids();
      w = exp_wr.pop_front();
      checks++; if (reg_wr_en !== 1'b1) begin errors++; $display("FAIL w2_en got %b exp 1", reg_wr_en); end
      checks++; if ({reg_wr_addr, reg_wr_data, reg_wr_strb} !== {w.addr, w.data, w.strb}) begin errors++; $display("FAIL w2_port got %h/%h/%h exp %h/%h/%h", reg_wr_addr, reg_wr_data, reg_wr_strb, w.addr, w.data, w.strb); end
      reg_wr_ack = 1'b1;
      tick();
      reg_wr_ack = 1'b0;
      r = exp_resp.pop_front();
      checks++; if ({bus.bvalid, bus.bresp} !== {1'b1, r}) begin errors++; $display("FAIL w2_b got %b/%b exp 1/%b", bus.bvalid, bus.bresp, r); end
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
   endtask

   // no ack; reg_wr_wait held for the first 'waits' enable cycles
   task automatic test_timeout(input int waits, input int exp_len);
      wr_t        w;
      logic [1:0] r;
      int         n;
      start_write(32'h302, 32'h0000_0055, 4'hF, BRESP_SLVERR);
      tick();
      clear_valids();
      w = exp_wr.pop_front();
      checks++; if (reg_wr_addr !== w.addr) begin errors++; $display("FAIL tmo_addr got %h exp %h", reg_wr_addr, w.addr); end
      n = 0;
      while (reg_wr_en === 1'b1 && n < 40) begin
         n++;
         reg_wr_wait = (n <= waits);
         tick();
      end
      reg_wr_wait = 1'b0;
      r = exp_resp.pop_front();
      checks++; if (n != exp_len) begin errors++; $display("FAIL tmo_len_w%0d got %0d exp %0d", waits, n, exp_len); end
      checks++; if ({bus.bvalid, bus.bresp} !== {1'b1, r}) begin errors++; $display("FAIL tmo_b got %b/%b exp 1/%b", bus.bvalid, bus.bresp, r); end
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic test_ack_at_expiry();
      wr_t        w;
      logic [1:0] r;
      start_write(32'h400, 32'h0000_00AA, 4'hF, BRESP_OKAY);
      tick();
      clear_valids();
      w = exp_wr.pop_front();
      checks++; if (reg_wr_data !== w.data) begin errors++; $display("FAIL expack_data got %h exp %h", reg_wr_data, w.data); end
      tick(); tick(); tick();
      // fourth enable cycle: counter is at zero
      checks++; if (reg_wr_en !== 1'b1) begin errors++; $display("FAIL expack_en got %b exp 1", reg_wr_en); end
      reg_wr_ack = 1'b1;
      tick();
      reg_wr_ack = 1'b0;
      r = exp_resp.pop_front();
      checks++; if ({bus.bvalid, bus.bresp} !== {1'b1, r}) begin errors++; $display("FAIL expack_b got %b/%b exp 1/%b", bus.bvalid, bus.bresp, r); end
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic test_back_to_back_stall();
      wr_t        w;
      logic [1:0] r;
      start_write(32'h500, 32'h1122_3344, 4'hF, BRESP_OKAY);
      tick();
      clear_valids();
      w = exp_wr.pop_front();
      checks++; if (reg_wr_addr !== w.addr) begin errors++; $display("FAIL stall_addr got %h exp %h", reg_wr_addr, w.addr); end
      reg_wr_ack = 1'b1;
      tick();
      reg_wr_ack = 1'b0;
      r = exp_resp.pop_front();
      start_write(32'h600, 32'h0000_0099, 4'h1, BRESP_OKAY);
      for (int i = 0; i < 10; i++) begin
         checks++; if ({bus.bvalid, bus.bresp} !== {1'b1, r}) begin errors++; $display("FAIL stall_b_c%0d got %b/%b exp 1/%b", i, bus.bvalid, bus.bresp, r); end
         checks++; if ({bus.awready, bus.wready, reg_wr_en} !== 3'b000) begin errors++; $display("FAIL stall_rdy_c%0d got %b exp 000", i, {bus.awready, bus.wready, reg_wr_en}); end
         tick();
      end
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      checks++; if ({bus.bvalid, reg_wr_en, bus.awready} !== 3'b001) begin errors++; $display("FAIL stall_after_b got %b exp 001", {bus.bvalid, reg_wr_en, bus.awready}); end
      tick();
      clear_valids();
      w = exp_wr.pop_front();
      checks++; if ({reg_wr_en, reg_wr_addr, reg_wr_strb} !== {1'b1, w.addr, w.strb}) begin errors++; $display("FAIL stall_next got %b/%h/%h exp 1/%h/%h", reg_wr_en, reg_wr_addr, reg_wr_strb, w.addr, w.strb); end
      reg_wr_ack = 1'b1;
      tick();
      reg_wr_ack = 1'b0;
      r = exp_resp.pop_front();
      checks++; if ({bus.bvalid, bus.bresp} !== {1'b1, r}) begin errors++; $display("FAIL stall_next_b got %b/%b exp 1/%b", bus.bvalid, bus.bresp, r); end
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic test_reset_mid();
      wr_t        w;
      logic [1:0] r;
      start_write(32'h700, 32'h0000_0077, 4'hF, BRESP_OKAY);
      tick();
      clear_valids();
      w = exp_wr.pop_front();
      checks++; if ({reg_wr_en, reg_wr_addr} !== {1'b1, w.addr}) begin errors++; $display("FAIL rmid_en got %b/%h exp 1/%h", reg_wr_en, reg_wr_addr, w.addr); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      // the interrupted write never answers; drop its queued response
      r = exp_resp.pop_front();
      checks++; if ({reg_wr_en, bus.bvalid} !== 2'b00) begin errors++; $display("FAIL rmid_drop got %b exp 00", {reg_wr_en, bus.bvalid}); end
      tick();
      checks++; if ({bus.awready, bus.wready} !== 2'b11) begin errors++; $display("FAIL rmid_ready got %b exp 11", {bus.awready, bus.wready}); end
      start_write(32'h806, 32'h0000_8888, 4'h5, BRESP_OKAY);
      tick();
      clear_valids();
      w = exp_wr.pop_front();
      checks++; if ({reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_strb} !== {1'b1, w.addr, w.data, w.strb}) begin errors++; $display("FAIL rmid_next got %b/%h/%h/%h exp 1/%h/%h/%h", reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_strb, w.addr, w.data, w.strb); end
      reg_wr_ack = 1'b1;
      tick();
      reg_wr_ack = 1'b0;
      r = exp_resp.pop_front();
      checks++; if ({bus.bvalid, bus.bresp} !== {1'b1, r}) begin errors++; $display("FAIL rmid_next_b got %b/%b exp 1/%b", bus.bvalid, bus.bresp, r); end
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL rmid_bdone got %b exp 0", bus.bvalid); end
   endtask

   initial begin
      bus.awaddr = '0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      test_reset();
      test_single();
      test_w_before_aw();
      test_timeout(0, 4);
      test_timeout(5, 9);
      test_ack_at_expiry();
      test_back_to_back_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

endmodule
